// File: rtl/dcache_req_unit.sv
// ---------------------------------------------------------------------------
// dcache_req_unit
// Memory-stage data-cache request unit. Accepts one load/store per handshake,
// checks alignment, builds byte write enables and lane-aligned store data,
// holds a word-aligned request until the cache takes it, then waits for the
// load response. Also keeps the func3 and byte address of the last accepted
// load so the load-extension stage can select and sign-extend the word.
// ---------------------------------------------------------------------------
module dcache_req_unit (
   input  logic        clk,
   input  logic        reset,

   // Pipeline side
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [2:0]  mem_func3,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ready,
   output logic        stall,
   output logic        misaligned,

   // Data-cache request side
   output logic        dcache_val,
   output logic        dcache_re,
   output logic [3:0]  dcache_we,
   output logic [31:0] dcache_addr,
   output logic [31:0] dcache_din,
   input  logic        dcache_ready,
   input  logic        dcache_resp_valid,

   // Load-extension side
   output logic [2:0]  wb_func3,
   output logic [31:0] wb_dcache_addr,
   output logic        wb_load_valid
);

   // RV32I load/store func3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;

   // Latched request
   logic [31:0] req_addr;
   logic [2:0]  req_func3;
   logic        req_we;
   logic [3:0]  req_mask;
   logic [31:0] req_din;

   // Decode of the op currently presented by the pipeline
   logic        op_mis;
   logic [3:0]  op_mask;
   logic [31:0] op_din;
   logic        accept;
   logic        accept_ok;
   logic        req_done;
   logic        resp_done;

   // Handshake terms
   assign mem_ready = (state == ST_IDLE);
   assign stall     = mem_valid && !mem_ready;
   assign accept    = mem_valid && mem_ready;
   assign accept_ok = accept && !op_mis;
   assign req_done  = (state == ST_REQ) && dcache_ready;
   assign resp_done = (state == ST_RESP) && dcache_resp_valid;

   // Alignment check, byte-enable mask and lane replication for the incoming op
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement leaves a value unassigned (no latches).
      op_mis  = 1'b0;
      op_mask = 4'b0000;
      op_din  = 32'h0;
      case (mem_func3)
         F3_B, F3_BU: begin
            op_mask = 4'b0001 << mem_addr[1:0];
            op_din  = {4{mem_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            op_mis  = mem_addr[0];
            op_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
            op_din  = {2{mem_wdata[15:0]}};
         end
         F3_W: begin
            op_mis  = |mem_addr[1:0];
            op_mask = 4'b1111;
            op_din  = mem_wdata;
         end
         default: begin
            // 011, 110, 111 have no RV32I load/store meaning
            op_mis = 1'b1;
         end
      endcase
      // Loads never write: clear the store-only fields
      if (!mem_we) begin
         op_mask = 4'b0000;
         op_din  = 32'h0;
      end
   end

   // Next-state logic: IDLE -> REQ on an aligned accept, REQ -> IDLE/RESP on
   // cache acceptance, RESP -> IDLE once the load data arrives
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept_ok) state_nxt = ST_REQ;
         ST_REQ:  if (req_done)  state_nxt = req_we ? ST_IDLE : ST_RESP;
         ST_RESP: if (resp_done) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // State register and one-cycle misaligned pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         misaligned <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         state      <= state_nxt;
         misaligned <= accept && op_mis;
      end
   end

   // Request registers: captured on an aligned accept, held through REQ
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_addr  <= 32'h0;
         req_func3 <= 3'b000;
         req_we    <= 1'b0;
         req_mask  <= 4'b0000;
         req_din   <= 32'h0;
      end else if (accept_ok) begin
         req_addr  <= mem_addr;
         req_func3 <= mem_func3;
         req_we    <= mem_we;
         req_mask  <= op_mask;
         req_din   <= op_din;
      end
   end

   // Load-extension context: updated when the cache takes a load request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_func3       <= 3'b000;
         wb_dcache_addr <= 32'h0;
      end else if (req_done && !req_we) begin
         wb_func3       <= req_func3;
         wb_dcache_addr <= req_addr;
      end
   end

   // Cache request outputs are qualified by state so reset drops them at once
   assign dcache_val    = (state == ST_REQ);
   assign dcache_re     = (state == ST_REQ) && !req_we;
   assign dcache_we     = (state == ST_REQ) ? req_mask : 4'b0000;
   assign dcache_addr   = {req_addr[31:2], 2'b00};
   assign dcache_din    = req_din;

   // Response is only meaningful while waiting for it
   assign wb_load_valid = resp_done;

endmodule
